isb_pf_queue: RTL
=================

# isb_pf_queue

Prefetch request queue directly downstream of the `isb` prefetcher. It accepts the prefetch addresses that `isb` emits as a valid/address stream and buffers them in an in-order FIFO. It suppresses duplicates against queued and recently issued addresses, then issues the survivors to the memory side over a valid/ready handshake. Overflow is dropped and counted; the prefetcher is never stalled.

## Interface
- `DEPTH`, 8, number of FIFO entries; power of two, ≥2
- `RECENT`, 4, entries in the recently-issued filter; ≥1

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `v_in`  in  1  prefetch candidate valid (from `isb`)
- `addr_in`  in  16  prefetch candidate address
- `flush`  in  1  synchronous clear of queue and filter
- `req_v`  out  1  request valid toward memory
- `req_addr`  out  16  request address
- `req_ready`  in  1  memory accepts request
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `drop_cnt`  out  16  saturating count of overflow drops

## Operation
- Storage: circular FIFO with head and tail pointers of width $clog2(DEPTH), wrapping modulo DEPTH; `count` is registered.
- Dequeue: `req_v` = (`count` != 0). `req_addr` = head entry when `req_v`=1, 16'h0000 otherwise.
- Transfer occurs at an edge where `req_v`=1 and `req_ready`=1. The head pops, and its address is shifted into the recent filter at slot 0; the oldest slot is evicted and its valid flag moves with it.
- Enqueue candidate: `v_in`=1 at an edge. Evaluate in priority order:
  1. **flush:** if `flush`=1, the candidate is discarded.
  2. **duplicate:** if `addr_in` equals any valid queued entry, including the head being popped this edge, or any valid recent-filter slot, the candidate is discarded silently.
  3. **full:** if `count`==DEPTH and no transfer occurs this edge, the candidate is discarded and `drop_cnt` increments, saturating at 16'hFFFF.
  4. **accept:** otherwise the candidate is written at tail, and tail advances.
- Full with a simultaneous transfer: the pop and push both occur; `count` stays DEPTH, and the new entry is accepted.
- Empty with a simultaneous `v_in`: the entry is accepted; the new entry cannot be issued on the same edge.
- `count` next value = `count` + push − pop.
- `flush`=1 at an edge:
  - Head, tail, `count` and all recent-filter valid flags clear.
  - `drop_cnt` is preserved.
  - If a transfer also occurs on that edge, it is considered complete (memory took it), but its address is not recorded in the filter.
- Reset (`rst_n`=0, any time, asynchronous):
  - `count`=0, `req_v`=0, `req_addr`=16'h0000, `drop_cnt`=0.
  - All filter valid flags clear; head and tail pointers go to 0.
  - Reset mid-operation discards all queued entries immediately, without waiting for a clock edge.

## Timing
- Latency: `v_in` sampled at edge N into an empty queue → `req_v`=1 with that address after edge N (1 cycle).
- `req_addr` is held stable while `req_v`=1 and `req_ready`=0; no reordering.
- `req_v` does not depend combinationally on `req_ready` or `v_in`; all outputs decode from registers only.
- Duplicate checks compare against state before the edge. Consequently, two back-to-back identical candidates in adjacent cycles: the first is enqueued, the second matches the queued copy and is filtered.
- Throughput: one enqueue and one dequeue per cycle sustained.

## Test plan
- Reset then single push: `v_in`=1, `addr_in`=16'h0010, `req_ready`=0 → next cycle `req_v`=1, `req_addr`=16'h0010, `count`=1. Assert `req_ready`=1 for one edge → `req_v`=0, `count`=0.
- In-order stream: push 16'h0010..16'h0014 on consecutive cycles with `req_ready`=1 → requests issue in order 0010, 0011, 0012, 0013, 0014, one per cycle, each one cycle after input.
- Duplicate filter:
  - Push 16'h0020 twice with `req_ready`=0 → `count`=1.
  - Issue it, then push 16'h0020 again → filtered, because it is in the recent filter, and `count` stays 0.
  - Issue RECENT other addresses, then push 16'h0020 → accepted.
- Overflow:
  - `req_ready`=0; push DEPTH+3 distinct addresses → `count`=DEPTH, `drop_cnt`=3, and `req_addr` stays the first address.
  - Then a push with `req_ready`=1 on a full queue → accepted, `count` stays DEPTH, and `drop_cnt` stays 3.
- Flush: with 5 entries queued, assert `flush`=1 together with `v_in`=1 and `addr_in`=16'h0030 → next cycle `count`=0, `req_v`=0, `drop_cnt` unchanged. Pushing a previously issued address is then accepted.
- Async reset mid-operation: queue 4 entries with `drop_cnt`=2; drop `rst_n` between edges → `req_v`=0, `count`=0, `drop_cnt`=0 immediately, before the next edge.

Source files
------------

// File: rtl/isb_pf_queue.sv
// Prefetch request queue behind the isb prefetcher: an in-order FIFO with duplicate
// suppression against queued and recently issued addresses, and counted overflow drops.
module isb_pf_queue #(
  parameter int DEPTH  = 8,
  parameter int RECENT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     v_in,
  input  logic [15:0]              addr_in,
  input  logic                     flush,
  output logic                     req_v,
  output logic [15:0]              req_addr,
  input  logic                     req_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]       mem_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       drop_q;
  logic [15:0]       rec_addr_q [RECENT];
  logic [RECENT-1:0] rec_v_q;

  logic              pop, push, drop_inc, dup, full;
  logic [DEPTH-1:0]  q_valid;
  logic [PW-1:0]     rel;

  assign req_v    = (count_q != '0);
  assign req_addr = req_v ? mem_q[head_q] : 16'h0000;
  assign count    = count_q;
  assign drop_cnt = drop_q;

  assign full = (count_q == CW'(DEPTH));
  assign pop  = req_v && req_ready;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    q_valid = '0;
    rel     = '0;
    dup     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rel        = PW'(i) - head_q;
      q_valid[i] = ({1'b0, rel} < count_q);
      if (q_valid[i] && (mem_q[i] == addr_in)) dup = 1'b1;
    end
    for (int j = 0; j < RECENT; j++) begin
      if (rec_v_q[j] && (rec_addr_q[j] == addr_in)) dup = 1'b1;
    end
  end

  assign push     = v_in && !flush && !dup && (!full || pop);
  assign drop_inc = v_in && !flush && !dup && full && !pop;
  assign count_d  = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      drop_q  <= '0;
      rec_v_q <= '0;
    end else begin
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        rec_v_q <= '0;
      end else begin
        if (pop)  head_q <= head_q + 1'b1;
        if (push) tail_q <= tail_q + 1'b1;
        count_q <= count_d;
        if (pop) begin
          for (int k = RECENT - 1; k > 0; k--) rec_v_q[k] <= rec_v_q[k-1];
          rec_v_q[0] <= 1'b1;
        end
      end
      if (drop_inc && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // NOTE: data arrays carry no reset; their contents are only observed through the
  // reset-cleared count and valid flags, so a reset here would only cost flops.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= addr_in;
    if (pop && !flush) begin
      for (int k = RECENT - 1; k > 0; k--) rec_addr_q[k] <= rec_addr_q[k-1];
      rec_addr_q[0] <= mem_q[head_q];
    end
  end

endmodule
